fp_addsub_sequencer: RTL
========================

// Module: fp_addsub_sequencer
// PURPOSE
//   Issue/writeback controller for the 4-cycle FP add/sub unit. Accepts one op
//   per cycle from the FP issue stage and tracks destination tags through a
//   LATENCY-deep valid/tag pipe. Pairs each tag with the unit's result and flags.
//   Freezes the unit through its clock enable on writeback backpressure.
//   Sequences the unit's multi-cycle reset and supports flush of in-flight ops.
// PARAMETERS
//   LATENCY     4   FP unit latency in enabled clocks (>=1)
//   TAG_W       5   destination register tag width
//   RST_CYCLES  2   cycles fu_rst_n_o is held low after rst_n_i deasserts (>=1)
// PORTS
//   clk_i           in   1       clock, single domain
//   rst_n_i         in   1       reset, synchronous, active-low
//   flush_i         in   1       discard all in-flight ops
//   issue_valid_i   in   1       issue request
//   issue_ready_o   out  1       issue accepted when valid&ready
//   issue_sub_i     in   1       0 = FADD, 1 = FSUB
//   issue_tag_i     in   TAG_W   destination tag
//   fu_op_valid_o   out  1       operand/operation valid to FP unit (= issue fire)
//   fu_op_sub_o     out  1       operation select to FP unit (= issue_sub_i)
//   fu_clk_en_o     out  1       FP unit clock enable
//   fu_rst_n_o      out  1       FP unit reset, active-low
//   fu_result_i     in   32      FP unit result
//   fu_flags_i      in   3       {invalid, overflow, underflow}
//   wb_valid_o      out  1       writeback valid
//   wb_ready_i      in   1       writeback accepted when valid&ready
//   wb_tag_o        out  TAG_W   tag of the result in writeback
//   wb_result_o     out  32      = fu_result_i
//   wb_flags_o      out  3       = fu_flags_i
//   busy_o          out  1       any op in flight, or not in RUN
//   inflight_o      out  $clog2(LATENCY+1)  in-flight op count
// BEHAVIOUR
//   FSM: RST_HOLD -> RUN. rst_n_i low forces RST_HOLD and clears the hold counter.
//   RST_HOLD: fu_rst_n_o=0, issue_ready_o=0. Go to RUN after RST_CYCLES cycles
//     with rst_n_i high. fu_rst_n_o=1 only in RUN.
//   Reset values: valid pipe, tags and inflight_o = 0; wb_valid_o=0,
//     issue_ready_o=0, fu_op_valid_o=0, busy_o=1.
//   Stall: stall = v[LATENCY] & ~wb_ready_i.
//     advance = ~stall, or state==RST_HOLD.
//   fu_clk_en_o = advance. The unit freezes, so the result stays stable while stalled.
//   issue_ready_o = (state==RUN) & advance & ~flush_i.
//     issue_fire = issue_valid_i & issue_ready_o.
//   On each advance edge: v[1]<=issue_fire, tag[1]<=issue_tag_i;
//     v[k]<=v[k-1], tag[k]<=tag[k-1].
//   No advance: pipe holds.
//   Latency: fire in cycle t -> wb_valid_o=1 in cycle t+LATENCY (no stalls).
//     Each stalled cycle adds one.
//   wb_valid_o = v[LATENCY], wb_tag_o = tag[LATENCY].
//     wb_fire = wb_valid_o & wb_ready_i.
//   Back-to-back: full throughput, one issue + one writeback per cycle when
//     wb_ready_i=1.
//   inflight_o: +1 on issue_fire, -1 on wb_fire, unchanged if both.
//     It cannot exceed LATENCY, since issue is blocked while stalled.
//   flush_i: next edge clears all v[] and sets inflight_o=0, even if stalled.
//     Same-cycle issue is rejected. wb_valid_o still reflects the current
//     v[LATENCY] in the flush cycle, and a wb_fire there is not counted.
//   busy_o = (state!=RUN) | (inflight_o!=0).
//   Reset mid-operation: all in-flight ops are dropped and no writeback occurs.
// TESTING
//   Reset: rst_n_i low 3 cycles then high -> fu_rst_n_o low for those cycles
//     plus 2 more; issue_ready_o first high in the 3rd cycle after release.
//   Single op: issue tag=5, sub=1 at cycle t, wb_ready_i=1 -> wb_valid_o=1,
//     wb_tag_o=5 only in cycle t+4; inflight_o 1,1,1,1,0.
//   Streaming: tags 1..8 on consecutive cycles, wb_ready_i=1 -> tags 1..8
//     written back in order on 8 consecutive cycles; issue_ready_o stays 1.
//   Backpressure: 4 ops issued, wb_ready_i=0 for 3 cycles when tag 1 reaches wb
//     -> fu_clk_en_o=0 and issue_ready_o=0 for 3 cycles; wb_tag_o/result held;
//     order preserved; no loss.
//   Flush: 3 ops in flight plus flush_i with issue_valid_i=1 -> issue rejected;
//     next cycle inflight_o=0 and no wb_valid_o for the flushed ops.
//   Mid-op reset: rst_n_i low with 2 in flight -> wb_valid_o=0 and
//     inflight_o=0 after the edge; RST_HOLD sequence repeats.

Source files
------------

// File: rtl/fp_addsub_sequencer.sv
// ---------------------------------------------------------------------------
// fp_addsub_sequencer
//   Issue/writeback controller for a fixed-latency FP add/sub unit.
//   Accepts at most one op per cycle and tracks its destination tag through a
//   LATENCY-deep valid/tag pipe that moves in lock-step with the unit. The tag
//   at the pipe tail is paired with the unit's result and flags. Writeback
//   backpressure freezes both the pipe and the unit through its clock enable.
//   The unit's reset is held for RST_CYCLES cycles after rst_n_i releases.
//   flush_i discards every op in flight.
//
//   Handshakes: a transfer happens on a rising clk edge when valid and ready
//   are both high. issue_ready_o is combinational from state, flush_i and
//   wb_ready_i. wb_valid_o never drops while waiting for wb_ready_i, except
//   when flush_i or rst_n_i discards the pending op.
//
// Ports
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   flush_i                     discard all in-flight ops on the next edge
//   issue_valid_i/ready_o       issue handshake; issue_sub_i, issue_tag_i payload
//   fu_op_valid_o, fu_op_sub_o  operation strobe and select to the FP unit
//   fu_clk_en_o, fu_rst_n_o     FP unit clock enable and active-low reset
//   fu_result_i, fu_flags_i     FP unit result and {invalid, overflow, underflow}
//   wb_valid_o/ready_i          writeback handshake; wb_tag_o, wb_result_o, wb_flags_o
//   busy_o                      op in flight, or unit still in reset
//   inflight_o                  number of ops in flight
// ---------------------------------------------------------------------------
module fp_addsub_sequencer #(
  parameter int LATENCY    = 4,
  parameter int TAG_W      = 5,
  parameter int RST_CYCLES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic                         issue_sub_i,
  input  logic [TAG_W-1:0]             issue_tag_i,
  output logic                         fu_op_valid_o,
  output logic                         fu_op_sub_o,
  output logic                         fu_clk_en_o,
  output logic                         fu_rst_n_o,
  input  logic [31:0]                  fu_result_i,
  input  logic [2:0]                   fu_flags_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [TAG_W-1:0]             wb_tag_o,
  output logic [31:0]                  wb_result_o,
  output logic [2:0]                   wb_flags_o,
  output logic                         busy_o,
  output logic [$clog2(LATENCY+1)-1:0] inflight_o
);

  localparam int INF_W = $clog2(LATENCY + 1);
  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic {
    ST_RST_HOLD = 1'b0,
    ST_RUN      = 1'b1
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   hold_cnt_q;

  logic [LATENCY:1]   v_q, v_d;
  logic [TAG_W-1:0]   tag_q [LATENCY:1];
  logic [TAG_W-1:0]   tag_d [LATENCY:1];
  logic [INF_W-1:0]   inflight_q, inflight_d;

  logic stall, advance, issue_ready, issue_fire, wb_fire;

  // The pipe only stalls when a finished op cannot leave. During the reset
  // hold the unit is clocked so its own reset takes effect.
  always_comb begin
    stall       = v_q[LATENCY] & ~wb_ready_i;
    advance     = ~stall | (state_q == ST_RST_HOLD);
    issue_ready = (state_q == ST_RUN) & advance & ~flush_i;
    issue_fire  = issue_valid_i & issue_ready;
    wb_fire     = v_q[LATENCY] & wb_ready_i;
  end

  always_comb begin
    v_d   = v_q;
    tag_d = tag_q;
    if (advance) begin
      v_d[1]   = issue_fire;
      tag_d[1] = issue_tag_i;
      for (int k = 2; k <= LATENCY; k++) begin
        v_d[k]   = v_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
    // Flush wins even while stalled; tags are don't-care once valids clear.
    if (flush_i) v_d = '0;
  end

  // A writeback in the flush cycle is not subtracted: the count goes to zero.
  always_comb begin
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = '0;
    end else begin
      case ({issue_fire, wb_fire})
        2'b10:   inflight_d = inflight_q + INF_W'(1);
        2'b01:   inflight_d = inflight_q - INF_W'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // Reset sequencer: count RST_CYCLES released cycles, then run.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RST_HOLD;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RST_HOLD: begin
          if (hold_cnt_q == CNT_W'(RST_CYCLES - 1)) state_q <= ST_RUN;
          else hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_RST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      v_q        <= '0;
      inflight_q <= '0;
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= '0;
    end else begin
      v_q        <= v_d;
      inflight_q <= inflight_d;
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign issue_ready_o = issue_ready;
  assign fu_op_valid_o = issue_fire;
  assign fu_op_sub_o   = issue_sub_i;
  assign fu_clk_en_o   = advance;
  assign fu_rst_n_o    = (state_q == ST_RUN);
  assign wb_valid_o    = v_q[LATENCY];
  assign wb_tag_o      = tag_q[LATENCY];
  assign wb_result_o   = fu_result_i;
  assign wb_flags_o    = fu_flags_i;
  assign busy_o        = (state_q != ST_RUN) | (inflight_q != '0);
  assign inflight_o    = inflight_q;

endmodule
